mcs_io_master: RTL and testbench
================================

// Module: mcs_io_master
// PURPOSE
//  Initiator for the MicroBlaze MCS IO bus: drives the same strobe/address/data/ready protocol the CPU drives into the bridge.
//  Accepts one read/write command at a time on a valid/ready interface and runs one IO-bus transaction per command.
//  Returns read data or a timeout error on a response handshake.
//  Used as a debug/traffic-generator master in front of FPro_Bridge.
// PARAMETERS
//  TIMEOUT_CYCLES  255  WAIT cycles without io_ready before the transaction is aborted with rsp_err=1
//  ERR_RDATA       32'hDEAD_BEEF  value returned on rsp_rdata when a read times out
// PORTS
//  clk              in   1   system clock; all logic on rising edge
//  reset            in   1   synchronous, active-high reset
//  cmd_valid        in   1   command present
//  cmd_ready        out  1   master idle; command accepted when cmd_valid & cmd_ready
//  cmd_write        in   1   1 = write, 0 = read
//  cmd_addr         in   32  byte address, passed unchanged to io_address
//  cmd_wdata        in   32  write data
//  cmd_be           in   4   byte enables (writes); reads always drive 4'b1111
//  rsp_valid        out  1   response available
//  rsp_ready        in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata        out  32  captured io_read_data (reads), 0 for writes, ERR_RDATA on read timeout
//  rsp_err          out  1   1 = transaction timed out
//  io_addr_strobe   out  1   one-cycle pulse marking transaction start
//  io_read_strobe   out  1   one-cycle pulse, read
//  io_write_strobe  out  1   one-cycle pulse, write
//  io_address       out  32  held stable from strobe cycle until transaction ends
//  io_byte_enable   out  4   held as io_address
//  io_write_data    out  32  held as io_address
//  io_read_data     in   32  sampled in the cycle io_ready=1
//  io_ready         in   1   responder completion, one-cycle pulse
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; all strobes 0; io_address/io_byte_enable/io_write_data=0; timeout count=0.
//  FSM IDLE -> STROBE -> WAIT -> RESP -> IDLE. cmd_ready = (state==IDLE), combinational from state.
//  IDLE: on accept (cycle N) register cmd fields into io_* outputs; next state STROBE.
//  STROBE (cycle N+1): io_addr_strobe=1 plus io_read_strobe or io_write_strobe per cmd_write; exactly one cycle.
//  io_ready is sampled in STROBE and WAIT. io_ready=1 in STROBE -> RESP directly (zero-wait responder); else -> WAIT.
//  WAIT: counter increments each cycle; io_ready=1 -> capture data, -> RESP; count reaches TIMEOUT_CYCLES-1 without ready -> rsp_err=1, -> RESP.
//  io_ready and timeout in the same cycle: ready wins, rsp_err=0.
//  Capture: reads rsp_rdata<=io_read_data; writes rsp_rdata<=0. Minimum latency accept->rsp_valid = 2 cycles.
//  RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake -> IDLE, rsp_valid=0; io_* outputs retain last value.
//  rsp_ready while not in RESP ignored; io_ready in IDLE or RESP ignored (late ready after timeout is dropped, no second response).
//  Counter clears on entry to STROBE; width $clog2(TIMEOUT_CYCLES+1); never wraps.
//  Reset mid-transaction: abandon immediately, return to reset values, no response produced.
// STRUCTURE
//  Package mcs_io_pkg: typedef enum logic [1:0] {IDLE,STROBE,WAIT,RESP} io_state_t; localparam logic [3:0] IO_BE_ALL=4'hF.
//  Single module; timeout counter inline (no sub-module). Registered outputs except cmd_ready.
// TESTING
//  Write addr 32'hC000_0010, data 32'h1234_5678, be 4'h3, io_ready 3 cycles after strobe -> one addr+write strobe pulse, fields held, rsp_valid, rsp_err=0, rsp_rdata=0.
//  Read 32'hC000_0004, io_ready in strobe cycle with io_read_data=32'hA5A5_0001 -> rsp_valid 2 cycles after accept, rsp_rdata=32'hA5A5_0001, be=4'hF.
//  Read, TIMEOUT_CYCLES=8, io_ready never -> rsp_err=1, rsp_rdata=ERR_RDATA after 8 WAIT cycles; late io_ready then ignored.
//  io_ready on final timeout cycle -> rsp_err=0, data captured.
//  rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, new cmd_valid not accepted.
//  reset asserted in WAIT -> next cycle all outputs at reset values, no rsp_valid; following command completes normally.

Source files
------------

// File: rtl/mcs_io_pkg.sv
// Shared types for the MCS IO-bus initiator.
package mcs_io_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} io_state_t;

  localparam logic [3:0] IO_BE_ALL = 4'hF;

endpackage

// File: rtl/mcs_io_master_if.sv
// Command/response handshake plus MCS IO-bus signals of the initiator.
interface mcs_io_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
           io_read_data, io_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           io_addr_strobe, io_read_strobe, io_write_strobe,
           io_address, io_byte_enable, io_write_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
           io_read_data, io_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           io_addr_strobe, io_read_strobe, io_write_strobe,
           io_address, io_byte_enable, io_write_data
  );

endinterface

// File: rtl/mcs_io_master.sv
// MCS IO-bus initiator: one valid/ready command becomes one strobe/ready
// bus transaction, answered on a response handshake with data or timeout.
module mcs_io_master
  import mcs_io_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic           clk,
  input  logic           reset,
  mcs_io_master_if.master bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  io_state_t        r_state;
  io_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic             r_addr_strobe, r_read_strobe, r_write_strobe;
  logic [31:0]      r_address, r_write_data, r_rsp_rdata;
  logic [3:0]       r_byte_enable;
  logic             r_rsp_valid, r_rsp_err;

  logic             w_accept, w_io_done, w_timeout, w_rsp_hs;
  logic [31:0]      w_rsp_rdata_nxt;

  assign bus.cmd_ready = (r_state == IDLE);

  assign w_accept  = bus.cmd_valid && (r_state == IDLE);
  // io_ready only counts while a transaction is on the bus; timeout loses to it
  assign w_io_done = bus.io_ready && ((r_state == STROBE) || (r_state == WAIT));
  assign w_timeout = (r_state == WAIT) && !bus.io_ready && (r_cnt == CNT_LAST);
  assign w_rsp_hs  = (r_state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = STROBE;
      STROBE:  w_state_nxt = w_io_done ? RESP : WAIT;
      WAIT:    if (w_io_done || w_timeout) w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rsp_rdata_nxt = 32'h0;
    if (!r_write) w_rsp_rdata_nxt = w_io_done ? bus.io_read_data : ERR_RDATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_write        <= 1'b0;
      r_addr_strobe  <= 1'b0;
      r_read_strobe  <= 1'b0;
      r_write_strobe <= 1'b0;
      r_address      <= 32'h0;
      r_byte_enable  <= 4'h0;
      r_write_data   <= 32'h0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= 32'h0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_addr_strobe  <= w_accept;
      r_read_strobe  <= w_accept && !bus.cmd_write;
      r_write_strobe <= w_accept && bus.cmd_write;
      if (w_accept) begin
        r_cnt         <= '0;
        r_write       <= bus.cmd_write;
        r_address     <= bus.cmd_addr;
        r_byte_enable <= bus.cmd_write ? bus.cmd_be : IO_BE_ALL;
        r_write_data  <= bus.cmd_wdata;
      end else if ((r_state == WAIT) && !w_io_done && !w_timeout) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_io_done || w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rsp_rdata_nxt;
        r_rsp_err   <= w_timeout;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.io_addr_strobe  = r_addr_strobe;
  assign bus.io_read_strobe  = r_read_strobe;
  assign bus.io_write_strobe = r_write_strobe;
  assign bus.io_address      = r_address;
  assign bus.io_byte_enable  = r_byte_enable;
  assign bus.io_write_data   = r_write_data;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_rdata       = r_rsp_rdata;
  assign bus.rsp_err         = r_rsp_err;

endmodule

// File: tb/tb_mcs_io_master.sv
// Directed bench for mcs_io_master with an 8-cycle timeout.
module tb_mcs_io_master;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  mcs_io_master_if bus ();

  mcs_io_master #(
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_be    = be;
  endtask

  task automatic rsp_hs();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_strobes"}, {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 0);
    chk({tag, "_io_address"}, bus.io_address, 0);
    chk({tag, "_io_be"}, bus.io_byte_enable, 0);
    chk({tag, "_io_wdata"}, bus.io_write_data, 0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_be = 4'h0;
    bus.rsp_ready = 1'b0;
    bus.io_read_data = 32'h0;
    bus.io_ready = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Write, responder ready three cycles after the strobe cycle
    set_cmd(1'b1, 32'hC000_0010, 32'h1234_5678, 4'h3);
    step();
    bus.cmd_valid = 1'b0;
    chk("wr_strobe", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 3'b101);
    chk("wr_addr", bus.io_address, 32'hC000_0010);
    chk("wr_be", bus.io_byte_enable, 4'h3);
    chk("wr_wdata", bus.io_write_data, 32'h1234_5678);
    chk("wr_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("wr_strobe_off", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 3'b000);
    step();
    chk("wr_addr_held", bus.io_address, 32'hC000_0010);
    step();
    chk("wr_no_rsp_yet", bus.rsp_valid, 0);
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'hFFFF_0000;
    step();
    bus.io_ready = 1'b0;
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_err", bus.rsp_err, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("wr_wdata_held", bus.io_write_data, 32'h1234_5678);
    rsp_hs();
    chk("wr_after_hs_valid", bus.rsp_valid, 0);
    chk("wr_after_hs_ready", bus.cmd_ready, 1);
    chk("wr_after_hs_addr", bus.io_address, 32'hC000_0010);

    // Read against a zero-wait responder
    set_cmd(1'b0, 32'hC000_0004, 32'h0, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    chk("rd0_strobe", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 3'b110);
    chk("rd0_be", bus.io_byte_enable, 4'hF);
    chk("rd0_addr", bus.io_address, 32'hC000_0004);
    chk("rd0_not_valid", bus.rsp_valid, 0);
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'hA5A5_0001;
    step();
    bus.io_ready = 1'b0;
    chk("rd0_rsp_valid", bus.rsp_valid, 1);
    chk("rd0_rsp_rdata", bus.rsp_rdata, 32'hA5A5_0001);
    chk("rd0_rsp_err", bus.rsp_err, 0);
    rsp_hs();

    // Read timeout, then a late ready that must be dropped
    set_cmd(1'b0, 32'hC000_0008, 32'h0, 4'hF);
    step();
    bus.cmd_valid = 1'b0;
    repeat (8) step();
    chk("to_last_wait_valid", bus.rsp_valid, 0);
    step();
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'h7777_7777;
    step();
    bus.io_ready = 1'b0;
    chk("to_late_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("to_late_err", bus.rsp_err, 1);
    rsp_hs();
    chk("to_hs_valid", bus.rsp_valid, 0);
    bus.io_ready = 1'b1;
    step();
    bus.io_ready = 1'b0;
    chk("to_idle_ready_ignored", bus.rsp_valid, 0);

    // Ready arrives on the final timeout cycle
    set_cmd(1'b0, 32'hC000_000C, 32'h0, 4'hF);
    step();
    bus.cmd_valid = 1'b0;
    repeat (8) step();
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'h1357_9BDF;
    step();
    bus.io_ready = 1'b0;
    chk("edge_rsp_valid", bus.rsp_valid, 1);
    chk("edge_rsp_err", bus.rsp_err, 0);
    chk("edge_rsp_rdata", bus.rsp_rdata, 32'h1357_9BDF);
    rsp_hs();

    // Response back-pressure with a new command waiting
    set_cmd(1'b0, 32'hC000_0014, 32'h0, 4'hF);
    step();
    set_cmd(1'b1, 32'hC000_0020, 32'hCAFE_0001, 4'hC);
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'h0000_00AA;
    step();
    bus.io_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h0000_00AA);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_no_strobe", bus.io_addr_strobe, 0);
      chk("bp_addr_held", bus.io_address, 32'hC000_0014);
    end
    rsp_hs();
    chk("bp_idle_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_next_strobe", {bus.io_addr_strobe, bus.io_read_strobe, bus.io_write_strobe}, 3'b101);
    chk("bp_next_addr", bus.io_address, 32'hC000_0020);
    chk("bp_next_be", bus.io_byte_enable, 4'hC);
    bus.io_ready = 1'b1;
    step();
    bus.io_ready = 1'b0;
    chk("bp_next_rdata", bus.rsp_rdata, 32'h0);
    chk("bp_next_valid", bus.rsp_valid, 1);
    rsp_hs();

    // Reset while waiting for the responder
    set_cmd(1'b1, 32'hC000_0030, 32'h0000_0055, 4'hF);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;
    step();
    chk("midrst_no_rsp", bus.rsp_valid, 0);
    set_cmd(1'b0, 32'hC000_0040, 32'h0, 4'hF);
    step();
    bus.cmd_valid = 1'b0;
    chk("post_rst_addr", bus.io_address, 32'hC000_0040);
    step();
    bus.io_ready = 1'b1;
    bus.io_read_data = 32'h0000_1234;
    step();
    bus.io_ready = 1'b0;
    chk("post_rst_valid", bus.rsp_valid, 1);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h0000_1234);
    chk("post_rst_err", bus.rsp_err, 0);
    rsp_hs();
    chk("post_rst_idle", bus.cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
